// File: rtl/reg_demux.sv
// Registered 1-to-2 demultiplexer: one ready/valid input steered by sel into two
// independent 2-entry FIFOs, so a stalled consumer never blocks the other output.

module reg_demux_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [1:0]       o_count,
   output logic [WIDTH-1:0] o_head
);
   logic [WIDTH-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= ~r_wptr;
         end
         if (i_pop)
            r_rptr <= ~r_rptr;
         // push+pop together leaves the count unchanged
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];
endmodule

module reg_demux #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel,
   input  logic [WIDTH-1:0] in,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1
);
   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0][1:0]       w_count;
   logic [NUM_LANES-1:0][WIDTH-1:0] w_head;
   logic [NUM_LANES-1:0]            w_valid;
   logic [NUM_LANES-1:0]            w_ready;
   logic [NUM_LANES-1:0]            w_lane_sel;
   logic [NUM_LANES-1:0]            w_push;
   logic [NUM_LANES-1:0]            w_pop;
   logic                            w_accept;

   // lane 0 is out0, chosen by sel=1 (same polarity as Mux)
   assign w_lane_sel = {~sel, sel};
   assign w_ready    = {out1_ready, out0_ready};
   assign in_ready   = sel ? (w_count[0] != 2'd2) : (w_count[1] != 2'd2);
   assign w_accept   = in_valid & in_ready;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_valid[g] = (w_count[g] != 2'd0);
      assign w_push[g]  = w_accept & w_lane_sel[g];
      assign w_pop[g]   = w_valid[g] & w_ready[g];

      reg_demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_wdata (in),
         .o_count (w_count[g]),
         .o_head  (w_head[g])
      );
   end

   assign out0_valid = w_valid[0];
   assign out1_valid = w_valid[1];
   assign out0       = w_head[0];
   assign out1       = w_head[1];
endmodule

// File: tb/tb_reg_demux.sv
// Directed vector table plus a scoreboarded random run for reg_demux.

module tb_reg_demux;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic         sel;
   logic [W-1:0] in;
   logic         out0_valid;
   logic         out0_ready;
   logic [W-1:0] out0;
   logic         out1_valid;
   logic         out1_ready;
   logic [W-1:0] out1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_demux #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .in         (in),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0       (out0),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1       (out1)
   );

   typedef struct {
      bit         rst;
      bit         iv;
      bit         sel;
      bit [W-1:0] din;
      bit         r0;
      bit         r1;
      bit         crdy;   // check in_ready before the edge
      bit         erdy;
      bit         ev0;
      bit [W-1:0] ed0;
      bit         ev1;
      bit [W-1:0] ed1;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];

   initial begin
      //                rst iv sel din    r0 r1 crdy erdy ev0 ed0    ev1 ed1
      vecs[0]  = '{1, 1, 1, 8'hAA, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00};
      vecs[1]  = '{1, 1, 1, 8'hAA, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00};
      vecs[2]  = '{0, 0, 1, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00};
      vecs[3]  = '{0, 1, 1, 8'h11, 1, 1, 1, 1, 1, 8'h11, 0, 8'h00};
      vecs[4]  = '{0, 1, 0, 8'h22, 1, 1, 1, 1, 0, 8'h00, 1, 8'h22};
      vecs[5]  = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00};
      vecs[6]  = '{0, 1, 1, 8'h01, 0, 1, 1, 1, 1, 8'h01, 0, 8'h00};
      vecs[7]  = '{0, 1, 1, 8'h02, 0, 1, 1, 1, 1, 8'h01, 0, 8'h00};
      vecs[8]  = '{0, 1, 1, 8'hFF, 0, 1, 1, 0, 1, 8'h01, 0, 8'h00};
      vecs[9]  = '{0, 1, 0, 8'h03, 0, 1, 1, 1, 1, 8'h01, 1, 8'h03};
      vecs[10] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 0, 8'h00};
      vecs[11] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00};
      vecs[12] = '{0, 1, 1, 8'h0A, 0, 0, 1, 1, 1, 8'h0A, 0, 8'h00};
      vecs[13] = '{0, 1, 1, 8'h0B, 0, 0, 1, 1, 1, 8'h0A, 0, 8'h00};
      vecs[14] = '{0, 1, 1, 8'h0C, 1, 0, 1, 0, 1, 8'h0B, 0, 8'h00};
      vecs[15] = '{0, 1, 1, 8'h0C, 0, 0, 1, 1, 1, 8'h0B, 0, 8'h00};
      vecs[16] = '{0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h0C, 0, 8'h00};
      vecs[17] = '{0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00};
      vecs[18] = '{0, 1, 0, 8'h05, 1, 0, 1, 1, 0, 8'h00, 1, 8'h05};
      vecs[19] = '{0, 1, 0, 8'h06, 1, 1, 1, 1, 0, 8'h00, 1, 8'h06};
      vecs[20] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 8'h00};
      vecs[21] = '{0, 1, 1, 8'h31, 0, 0, 1, 1, 1, 8'h31, 0, 8'h00};
      vecs[22] = '{0, 1, 1, 8'h32, 0, 0, 1, 1, 1, 8'h31, 0, 8'h00};
      vecs[23] = '{0, 1, 0, 8'h41, 0, 0, 1, 1, 1, 8'h31, 1, 8'h41};
      vecs[24] = '{0, 1, 0, 8'h42, 0, 0, 1, 1, 1, 8'h31, 1, 8'h41};
      vecs[25] = '{1, 1, 0, 8'h43, 1, 1, 1, 0, 0, 8'h00, 0, 8'h00};
      vecs[26] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 0, 8'h00};

      reset = 1'b1; in_valid = 1'b0; sel = 1'b0; in = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset = vecs[i].rst; in_valid = vecs[i].iv; sel = vecs[i].sel;
         in = vecs[i].din; out0_ready = vecs[i].r0; out1_ready = vecs[i].r1;
         #1;
         if (vecs[i].crdy) chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].erdy));
         @(posedge clk); #1;
         chk($sformatf("v%0d out0_valid", i), 32'(out0_valid), 32'(vecs[i].ev0));
         chk($sformatf("v%0d out1_valid", i), 32'(out1_valid), 32'(vecs[i].ev1));
         if (vecs[i].ev0 || vecs[i].rst) chk($sformatf("v%0d out0", i), 32'(out0), 32'(vecs[i].ed0));
         if (vecs[i].ev1 || vecs[i].rst) chk($sformatf("v%0d out1", i), 32'(out1), 32'(vecs[i].ed1));
      end

      // random traffic against queue models; buffers are empty after the last vector
      for (int c = 0; c < 1000; c++) begin
         logic m_rdy;
         logic acc;
         logic p0;
         logic p1;
         @(negedge clk);
         reset = 1'b0;
         in_valid = ($urandom_range(0, 3) != 0);
         sel = 1'($urandom_range(0, 1));
         in = W'($urandom);
         out0_ready = ($urandom_range(0, 2) != 0);
         out1_ready = ($urandom_range(0, 2) == 0);
         #1;
         m_rdy = sel ? (q0.size() < 2) : (q1.size() < 2);
         chk("rnd in_ready", 32'(in_ready), 32'(m_rdy));
         chk("rnd out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
         chk("rnd out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
         if (q0.size() != 0) chk("rnd out0", 32'(out0), 32'(q0[0]));
         if (q1.size() != 0) chk("rnd out1", 32'(out1), 32'(q1[0]));
         acc = in_valid & m_rdy;
         p0  = (q0.size() != 0) & out0_ready;
         p1  = (q1.size() != 0) & out1_ready;
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
         if (acc) begin
            if (sel) q0.push_back(in);
            else     q1.push_back(in);
         end
         @(posedge clk);
      end

      // drain and confirm the tail of each stream
      @(negedge clk);
      in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("drain out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
         chk("drain out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
         if (q0.size() != 0) begin chk("drain out0", 32'(out0), 32'(q0[0])); void'(q0.pop_front()); end
         if (q1.size() != 0) begin chk("drain out1", 32'(out1), 32'(q1[0])); void'(q1.pop_front()); end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
